cdb_arbiter: RTL and testbench

- Shares the single ROB result write-back bus (the alu_num/alu_value-style tag+value pair) among several functional-unit producers: ALU, load/store unit, branch unit.
- Each producer gets a one-entry holding register with a valid/ready handshake.
- Holding registers are arbitrated round-robin; at most one result per cycle goes out as a registered tag/value.
- Tag 0 means "no result", the same convention used across the core.

---
 rtl/cdb_arbiter.sv | 271 +++++++++++++++++++++++++++
 tb/tb_cdb_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Shares the single ROB result write-back bus (tag + value) among NUM_SRC
// functional-unit producers (ALU, load/store unit, branch unit, ...).
// Each producer owns a one-entry holding register fed through a valid/ready
// handshake. The holding registers are arbitrated round-robin, and at most
// one result per cycle goes out on the registered cdb_tag/cdb_value pair.
// Tag 0 means "no result" everywhere in the core.
//
// Optional feature (compile-time macro CDB_BYPASS_EN):
//   When defined, if every holding register is empty and no flush is
//   pending, the incoming beats join arbitration directly. The winner reaches
//   the bus on its acceptance edge and the losers are parked in their hold
//   registers. When undefined, every result passes through a hold register.
//
// Ports:
//   clk        core clock, all state updates on the rising edge
//   rst        asynchronous active-low reset (0 = reset asserted)
//   flush      synchronous pipeline flush, highest priority
//   src_valid  per-producer valid
//   src_tag    per-producer ROB tag, slice [i*TAG_W +: TAG_W]
//   src_data   per-producer result, slice [i*DATA_W +: DATA_W]
//   src_ready  per-producer ready (registered state and flush only)
//   cdb_tag    ROB entry written this cycle, 0 = none
//   cdb_value  result value for cdb_tag (holds its last value when idle)
//   cdb_src    one-hot source of the current bus beat
//   busy       at least one holding register is occupied
// ---------------------------------------------------------------------------
module cdb_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int TAG_W   = 3,
    parameter int DATA_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic [NUM_SRC*TAG_W-1:0]    src_tag,
    input  logic [NUM_SRC*DATA_W-1:0]   src_data,
    output logic [NUM_SRC-1:0]          src_ready,
    output logic [TAG_W-1:0]            cdb_tag,
    output logic [DATA_W-1:0]           cdb_value,
    output logic [NUM_SRC-1:0]          cdb_src,
    output logic                        busy
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // Round-robin pick: lowest requester at or above ptr, otherwise wrap to
    // the lowest requester overall. Result is one-hot or zero.
    function automatic logic [NUM_SRC-1:0] rr_pick(
        input logic [NUM_SRC-1:0] req,
        input logic [PTR_W-1:0]   ptr
    );
        logic [NUM_SRC-1:0] hi_req;
        logic [NUM_SRC-1:0] gnt;
        logic               found;
        hi_req = '0;
        gnt    = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            hi_req[i] = req[i] & (i >= int'(ptr));
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && hi_req[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end else begin
                gnt[i] = gnt[i];
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && req[i]) begin
                gnt[i] = 1'b1;
                found  = 1'b1;
            end else begin
                gnt[i] = gnt[i];
            end
        end
        return gnt;
    endfunction

    // Pointer value one past the granted index, wrapping to 0.
    function automatic logic [PTR_W-1:0] next_ptr(
        input logic [NUM_SRC-1:0] gnt
    );
        logic [PTR_W-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_SRC - 1; i++) begin
            if (gnt[i]) begin
                p = PTR_W'(i + 1);
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

    // Registered state
    logic [NUM_SRC-1:0] hold_v_q,    hold_v_d;
    logic [TAG_W-1:0]   hold_tag_q  [NUM_SRC];
    logic [TAG_W-1:0]   hold_tag_d  [NUM_SRC];
    logic [DATA_W-1:0]  hold_data_q [NUM_SRC];
    logic [DATA_W-1:0]  hold_data_d [NUM_SRC];
    logic [PTR_W-1:0]   rr_ptr_q,    rr_ptr_d;
    logic [TAG_W-1:0]   cdb_tag_q,   cdb_tag_d;
    logic [DATA_W-1:0]  cdb_value_q, cdb_value_d;
    logic [NUM_SRC-1:0] cdb_src_q,   cdb_src_d;
    logic               busy_q,      busy_d;

    // Combinational helpers
    logic [TAG_W-1:0]   in_tag_s  [NUM_SRC];
    logic [DATA_W-1:0]  in_data_s [NUM_SRC];
    logic [NUM_SRC-1:0] in_nz_s;
    logic [NUM_SRC-1:0] hold_grant_s;
    logic [NUM_SRC-1:0] ready_s;
    logic [NUM_SRC-1:0] accept_s;
    logic [NUM_SRC-1:0] grant_s;
    logic [NUM_SRC-1:0] byp_win_s;
    logic [TAG_W-1:0]   win_tag_s;
    logic [DATA_W-1:0]  win_data_s;

    // Unpack the flat producer buses and flag non-idle tags.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            in_tag_s[i]  = src_tag[i*TAG_W +: TAG_W];
            in_data_s[i] = src_data[i*DATA_W +: DATA_W];
            in_nz_s[i]   = (in_tag_s[i] != '0);
        end
    end

    // Handshake: ready depends only on registered hold state, rst and flush,
    // so a producer can reload a register in the same cycle it is granted.
    always_comb begin
        hold_grant_s = rr_pick(hold_v_q, rr_ptr_q);
        ready_s      = {NUM_SRC{rst & ~flush}} & (~hold_v_q | hold_grant_s);
        accept_s     = src_valid & ready_s & in_nz_s;
    end

`ifdef CDB_BYPASS_EN
    logic bypass_act_s;

    // Bypass arbitration: with every hold empty the live beats compete
    // directly; otherwise only the hold registers compete.
    always_comb begin
        bypass_act_s = (hold_v_q == '0) & ~flush;
        win_tag_s    = '0;
        win_data_s   = '0;
        if (bypass_act_s) begin
            grant_s   = rr_pick(accept_s, rr_ptr_q);
            byp_win_s = grant_s;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant_s[i]) begin
                    win_tag_s  = in_tag_s[i];
                    win_data_s = in_data_s[i];
                end else begin
                    win_tag_s  = win_tag_s;
                    win_data_s = win_data_s;
                end
            end
        end else begin
            grant_s   = hold_grant_s;
            byp_win_s = '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant_s[i]) begin
                    win_tag_s  = hold_tag_q[i];
                    win_data_s = hold_data_q[i];
                end else begin
                    win_tag_s  = win_tag_s;
                    win_data_s = win_data_s;
                end
            end
        end
    end
`else
    // Plain arbitration: only hold registers compete for the bus.
    always_comb begin
        grant_s    = hold_grant_s;
        byp_win_s  = '0;
        win_tag_s  = '0;
        win_data_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_s[i]) begin
                win_tag_s  = hold_tag_q[i];
                win_data_s = hold_data_q[i];
            end else begin
                win_tag_s  = win_tag_s;
                win_data_s = win_data_s;
            end
        end
    end
`endif

    // Hold register next state. A reload on the grant edge takes priority
    // over the clear, so a lone producer streams one beat per cycle.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            hold_v_d[i]    = hold_v_q[i];
            hold_tag_d[i]  = hold_tag_q[i];
            hold_data_d[i] = hold_data_q[i];
            if (flush) begin
                hold_v_d[i] = 1'b0;
            end else if (accept_s[i] && !byp_win_s[i]) begin
                hold_v_d[i]    = 1'b1;
                hold_tag_d[i]  = in_tag_s[i];
                hold_data_d[i] = in_data_s[i];
            end else if (grant_s[i]) begin
                hold_v_d[i] = 1'b0;
            end else begin
                hold_v_d[i] = hold_v_q[i];
            end
        end
        busy_d = |hold_v_d;
    end

    // Bus and pointer next state. Flush suppresses the beat but leaves the
    // pointer alone; an idle cycle keeps the last value to avoid toggling.
    always_comb begin
        cdb_tag_d   = cdb_tag_q;
        cdb_value_d = cdb_value_q;
        cdb_src_d   = cdb_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (flush) begin
            cdb_tag_d = '0;
            cdb_src_d = '0;
        end else if (grant_s != '0) begin
            cdb_tag_d   = win_tag_s;
            cdb_value_d = win_data_s;
            cdb_src_d   = grant_s;
            rr_ptr_d    = next_ptr(grant_s);
        end else begin
            cdb_tag_d = '0;
            cdb_src_d = '0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_v_q    <= '0;
            rr_ptr_q    <= '0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
            cdb_src_q   <= '0;
            busy_q      <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) begin
                hold_tag_q[i]  <= '0;
                hold_data_q[i] <= '0;
            end
        end else begin
            hold_v_q    <= hold_v_d;
            rr_ptr_q    <= rr_ptr_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
            cdb_src_q   <= cdb_src_d;
            busy_q      <= busy_d;
            for (int i = 0; i < NUM_SRC; i++) begin
                hold_tag_q[i]  <= hold_tag_d[i];
                hold_data_q[i] <= hold_data_d[i];
            end
        end
    end

    assign src_ready = ready_s;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_value = cdb_value_q;
    assign cdb_src   = cdb_src_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cdb_arbiter
//
// Self-checking bench for cdb_arbiter (NUM_SRC=3, TAG_W=3, DATA_W=32).
// Expected bus beats are queued when stimulus is driven and popped by a
// monitor each time the bus carries a non-zero tag. Direct checks cover
// reset, handshake readiness, busy, flush and idle behaviour.
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;

    localparam int NUM_SRC = 3;
    localparam int TAG_W   = 3;
    localparam int DATA_W  = 32;
`ifdef CDB_BYPASS_EN
    localparam int BYP = 1;
`else
    localparam int BYP = 0;
`endif
    localparam int FAIR_K = 6;

    logic                      clk;
    logic                      rst;
    logic                      flush;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC*TAG_W-1:0]  src_tag;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [NUM_SRC-1:0]        src_ready;
    logic [TAG_W-1:0]          cdb_tag;
    logic [DATA_W-1:0]         cdb_value;
    logic [NUM_SRC-1:0]        cdb_src;
    logic                      busy;

    typedef struct packed {
        logic [NUM_SRC-1:0] src;
        logic [TAG_W-1:0]   tag;
        logic [DATA_W-1:0]  val;
    } beat_t;

    beat_t sb_q[$];
    int    err_cnt   = 0;
    int    check_cnt = 0;

    cdb_arbiter #(.NUM_SRC(NUM_SRC), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .src_valid (src_valid),
        .src_tag   (src_tag),
        .src_data  (src_data),
        .src_ready (src_ready),
        .cdb_tag   (cdb_tag),
        .cdb_value (cdb_value),
        .cdb_src   (cdb_src),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        check_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic expect_beat(input logic [NUM_SRC-1:0] s, input logic [TAG_W-1:0] t,
                               input logic [DATA_W-1:0] v);
        beat_t b;
        b.src = s;
        b.tag = t;
        b.val = v;
        sb_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every non-idle bus beat must match the queue head.
    always @(negedge clk) begin
        beat_t b;
        if (cdb_tag != 3'd0) begin
            if (sb_q.size() == 0) begin
                check_eq("cdb_unexpected", 64'(cdb_tag), 64'd0);
            end else begin
                b = sb_q.pop_front();
                check_eq("cdb_beat", 64'({cdb_src, cdb_tag, cdb_value}), 64'(b));
            end
        end
    end

    initial begin
        // ---------------- reset ----------------
        rst       = 1'b0;
        flush     = 1'b0;
        src_valid = 3'b111;
        src_tag   = {3'd5, 3'd2, 3'd1};
        src_data  = {32'h0000_cccc, 32'h0000_bbbb, 32'h0000_aaaa};
        repeat (3) tick();
        check_eq("rst_ready", 64'(src_ready), 64'd0);
        check_eq("rst_tag",   64'(cdb_tag),   64'd0);
        check_eq("rst_busy",  64'(busy),      64'd0);
        check_eq("rst_src",   64'(cdb_src),   64'd0);
        check_eq("rst_value", 64'(cdb_value), 64'd0);
        rst       = 1'b1;
        src_valid = 3'b000;
        #1;
        check_eq("rel_ready", 64'(src_ready), 64'b111);
        tick();

        // ---------------- contention (rr_ptr = 0) ----------------
        src_valid = 3'b111;
        expect_beat(3'b001, 3'd1, 32'h0000_aaaa);
        expect_beat(3'b010, 3'd2, 32'h0000_bbbb);
        expect_beat(3'b100, 3'd5, 32'h0000_cccc);
        tick();
        src_valid = 3'b000;
`ifdef CDB_BYPASS_EN
        check_eq("cont_tag0", 64'(cdb_tag), 64'd1);
        tick();
        check_eq("cont_tag1", 64'(cdb_tag), 64'd2);
        tick();
        check_eq("cont_tag2", 64'(cdb_tag), 64'd5);
        tick();
`else
        check_eq("cont_ready0", 64'(src_ready), 64'b001);
        check_eq("cont_busy",   64'(busy),      64'd1);
        tick();
        check_eq("cont_tag0",   64'(cdb_tag),   64'd1);
        check_eq("cont_ready1", 64'(src_ready), 64'b011);
        tick();
        check_eq("cont_tag1",   64'(cdb_tag),   64'd2);
        check_eq("cont_ready2", 64'(src_ready), 64'b111);
        tick();
        check_eq("cont_tag2",   64'(cdb_tag),   64'd5);
        tick();
`endif
        check_eq("idle_tag",   64'(cdb_tag),   64'd0);
        check_eq("idle_src",   64'(cdb_src),   64'd0);
        check_eq("idle_value", 64'(cdb_value), 64'h0000_cccc);
        check_eq("idle_busy",  64'(busy),      64'd0);

        // ---------------- single beat ----------------
        src_valid = 3'b001;
        src_tag   = {3'd0, 3'd0, 3'd3};
        src_data  = {32'd0, 32'd0, 32'h0000_1234};
        expect_beat(3'b001, 3'd3, 32'h0000_1234);
        tick();
        src_valid = 3'b000;
`ifdef CDB_BYPASS_EN
        check_eq("single_tag",  64'(cdb_tag), 64'd3);
        check_eq("single_busy", 64'(busy),    64'd0);
        tick();
`else
        check_eq("single_early", 64'(cdb_tag), 64'd0);
        check_eq("single_busy",  64'(busy),    64'd1);
        tick();
        check_eq("single_tag",   64'(cdb_tag), 64'd3);
        check_eq("single_value", 64'(cdb_value), 64'h0000_1234);
        tick();
`endif
        check_eq("single_after", 64'(cdb_tag), 64'd0);

        // ---------------- fairness (rr_ptr = 1) ----------------
        src_valid = 3'b101;
        src_tag   = {3'd6, 3'd0, 3'd4};
        src_data  = {32'h0000_6666, 32'd0, 32'h0000_4444};
        for (int i = 0; i < FAIR_K + 1 + BYP; i++) begin
            if (i % 2 == 0) expect_beat(3'b100, 3'd6, 32'h0000_6666);
            else            expect_beat(3'b001, 3'd4, 32'h0000_4444);
        end
        repeat (FAIR_K) tick();
        src_valid = 3'b000;
        repeat (3) tick();
        check_eq("fair_busy", 64'(busy), 64'd0);

        // ---------------- flush ----------------
        src_tag  = {3'd0, 3'd7, 3'd2};
        src_data = {32'd0, 32'h0000_7777, 32'h0000_2222};
`ifndef CDB_BYPASS_EN
        src_valid = 3'b011;
        tick();
        check_eq("flush_pre_busy", 64'(busy), 64'd1);
`endif
        src_valid = 3'b011;
        flush     = 1'b1;
        #1;
        check_eq("flush_ready", 64'(src_ready), 64'd0);
        tick();
        flush     = 1'b0;
        src_valid = 3'b000;
        check_eq("flush_busy", 64'(busy),    64'd0);
        check_eq("flush_tag",  64'(cdb_tag), 64'd0);
        tick();
        check_eq("flush_tag2", 64'(cdb_tag), 64'd0);

        // ---------------- tag zero dropped ----------------
        src_valid = 3'b010;
        src_tag   = {3'd0, 3'd0, 3'd0};
        src_data  = {32'd0, 32'h0000_dead, 32'd0};
        tick();
        src_valid = 3'b000;
        check_eq("tag0_busy", 64'(busy), 64'd0);
        tick();
        check_eq("tag0_cdb", 64'(cdb_tag), 64'd0);

        // ---------------- back-to-back from one source ----------------
        src_valid = 3'b010;
        src_tag   = {3'd0, 3'd3, 3'd0};
        src_data  = {32'd0, 32'h0000_3333, 32'd0};
        expect_beat(3'b010, 3'd3, 32'h0000_3333);
        expect_beat(3'b010, 3'd4, 32'h0000_4444);
        tick();
        check_eq("b2b_ready", 64'(src_ready), 64'b111);
`ifdef CDB_BYPASS_EN
        check_eq("b2b_first", 64'(cdb_tag), 64'd3);
`endif
        src_tag  = {3'd0, 3'd4, 3'd0};
        src_data = {32'd0, 32'h0000_4444, 32'd0};
        tick();
        src_valid = 3'b000;
`ifdef CDB_BYPASS_EN
        check_eq("b2b_second", 64'(cdb_tag), 64'd4);
`else
        check_eq("b2b_first",  64'(cdb_tag), 64'd3);
        tick();
        check_eq("b2b_second", 64'(cdb_tag), 64'd4);
`endif
        tick();
        check_eq("b2b_after", 64'(cdb_tag), 64'd0);

        // ---------------- reset mid-operation ----------------
        src_valid = 3'b100;
        src_tag   = {3'd6, 3'd0, 3'd0};
        src_data  = {32'h0000_6060, 32'd0, 32'd0};
        tick();
        src_valid = 3'b000;
`ifdef CDB_BYPASS_EN
        check_eq("mid_byp_tag", 64'(cdb_tag), 64'd6);
`else
        check_eq("mid_pre_busy", 64'(busy), 64'd1);
`endif
        rst = 1'b0;
        #1;
        check_eq("mid_busy",  64'(busy),      64'd0);
        check_eq("mid_tag",   64'(cdb_tag),   64'd0);
        check_eq("mid_ready", 64'(src_ready), 64'd0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();
        check_eq("mid_after", 64'(cdb_tag), 64'd0);

        repeat (2) tick();
        check_eq("sb_drain", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, check_cnt);
        $finish;
    end

endmodule
